icache_refill_ctrl: RTL and testbench

Miss-handling controller for the L1 instruction cache, sitting between the fetch stage and the instruction-cache SRAM array, with a word-wide port to main memory on the other side. Fetch lookups go straight to the array. On a miss, the controller stalls fetch and requests the block from memory. It assembles the returned beats into a line buffer, writes the line into the array, and replays the lookup.

---
 rtl/icache_pkg.sv | 18 +
 rtl/icache_line_assembler.sv | 36 +++
 rtl/icache_refill_ctrl.sv | 88 ++++++++
 tb/tb_icache_refill_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and address-split helpers for the I-cache refill path
package icache_pkg;

    typedef enum logic [1:0] {LOOKUP, REQ, REFILL, WRITE} state_e;

    function automatic int off_w_of(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic logic [63:0] block_addr(input logic [63:0] addr, input int off_w);
        return addr >> (off_w + 2);
    endfunction

    function automatic logic [63:0] word_off(input logic [63:0] addr, input int off_w);
        return (addr >> 2) & ((64'd1 << off_w) - 64'd1);
    endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// icache_line_assembler: beat counter and line buffer collecting refill beats in ascending order
module icache_line_assembler
    import icache_pkg::*;
#(
    parameter int BLOCK_WORDS = 4,
    parameter int OFF_W       = off_w_of(BLOCK_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      valid_i,
    input  logic [31:0]               data_i,
    output logic                      last_o,
    output logic [32*BLOCK_WORDS-1:0] line_o
);

    logic [OFF_W-1:0]             beat_q;
    logic [BLOCK_WORDS-1:0][31:0] line_q;

    assign last_o = beat_q == OFF_W'(BLOCK_WORDS - 1);
    assign line_o = line_q;

    // Each accepted beat lands in the slot named by the counter, which then advances
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            line_q <= '0;
        end else if (clr_i) begin
            beat_q <= '0;
        end else if (valid_i) begin
            line_q[beat_q] <= data_i;
            beat_q         <= beat_q + 1'b1;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: L1 I-cache miss FSM that stalls fetch, refills a block from memory and replays
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int BLOCK_WORDS  = 4,
    parameter int OFF_W        = off_w_of(BLOCK_WORDS),
    parameter int BLOCK_ADDR_W = ADDR_W - 2 - OFF_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic [ADDR_W-1:0]         cpu_addr,
    output logic [31:0]               cpu_instr,
    output logic                      cpu_stall,
    output logic                      sram_ren,
    output logic                      sram_wen,
    output logic [BLOCK_ADDR_W-1:0]   sram_block_addr,
    output logic [32*BLOCK_WORDS-1:0] sram_data_in,
    input  logic                      sram_hit,
    input  logic [32*BLOCK_WORDS-1:0] sram_data_out,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_valid,
    input  logic [31:0]               mem_data
);

    state_e                       state_q, state_d;
    logic [BLOCK_ADDR_W-1:0]      miss_q, miss_d, cpu_blk;
    logic [OFF_W-1:0]             cpu_off;
    logic [BLOCK_WORDS-1:0][31:0] rd_words;
    logic                         in_lookup, last;

    assign cpu_blk   = BLOCK_ADDR_W'(block_addr(64'(cpu_addr), OFF_W));
    assign cpu_off   = OFF_W'(word_off(64'(cpu_addr), OFF_W));
    assign rd_words  = sram_data_out;
    assign in_lookup = state_q == LOOKUP;

    // Array reads only happen in LOOKUP so the victim chosen at the miss stays put through the refill
    assign sram_ren        = in_lookup && cpu_req;
    assign sram_wen        = state_q == WRITE;
    assign sram_block_addr = in_lookup ? cpu_blk : miss_q;
    assign cpu_stall       = in_lookup ? cpu_req && !sram_hit : 1'b1;
    assign cpu_instr       = (in_lookup && cpu_req && sram_hit) ? rd_words[cpu_off] : 32'd0;
    assign mem_req         = state_q == REQ;
    assign mem_addr        = {miss_q, {(OFF_W + 2){1'b0}}};

    icache_line_assembler #(
        .BLOCK_WORDS(BLOCK_WORDS),
        .OFF_W      (OFF_W)
    ) u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == REQ && mem_gnt),
        .valid_i(state_q == REFILL && mem_valid),
        .data_i (mem_data),
        .last_o (last),
        .line_o (sram_data_in)
    );

    // State and latched miss block address; reset discards any refill in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOOKUP;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    // Next state: miss -> request -> collect beats -> one write cycle -> replay lookup
    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        case (state_q)
            LOOKUP: if (cpu_req && !sram_hit) begin
                state_d = REQ;
                miss_d  = cpu_blk;
            end
            REQ:     state_d = mem_gnt ? REFILL : REQ;
            REFILL:  state_d = (mem_valid && last) ? WRITE : REFILL;
            default: state_d = LOOKUP;
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed self-checking bench with a small direct-mapped array model
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_instr;
    logic         cpu_stall;
    logic         sram_ren;
    logic         sram_wen;
    logic [27:0]  sram_block_addr;
    logic [127:0] sram_data_in;
    logic         sram_hit;
    logic [127:0] sram_data_out;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_valid;
    logic [31:0]  mem_data;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls;

    logic [7:0]   v;
    logic [27:0]  tg  [8];
    logic [127:0] dat [8];

    icache_refill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_instr      (cpu_instr),
        .cpu_stall      (cpu_stall),
        .sram_ren       (sram_ren),
        .sram_wen       (sram_wen),
        .sram_block_addr(sram_block_addr),
        .sram_data_in   (sram_data_in),
        .sram_hit       (sram_hit),
        .sram_data_out  (sram_data_out),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;

    assign sram_hit      = v[sram_block_addr[2:0]] && tg[sram_block_addr[2:0]] == sram_block_addr;
    assign sram_data_out = dat[sram_block_addr[2:0]];

    // Array model: direct-mapped on the low block-address bits, filled by sram_wen
    always @(posedge clk) begin
        if (rst) v <= '0;
        else if (sram_wen) begin
            v[sram_block_addr[2:0]]   <= 1'b1;
            tg[sram_block_addr[2:0]]  <= sram_block_addr;
            dat[sram_block_addr[2:0]] <= sram_data_in;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Caller has raised a missing fetch; serve the memory side and stop inside the WRITE cycle
    task automatic refill(input logic [31:0] base, input logic [31:0] bv, input int gdly,
                          input int gap, input bit disturb, input bit sgnt, output int st);
        logic [27:0]  blk;
        logic [127:0] ln;
        blk = base[31:4];
        ln  = {bv + 32'd3, bv + 32'd2, bv + 32'd1, bv};
        st  = 0;
        #1;
        st += int'(cpu_stall);
        check("miss_stall", cpu_stall, 1'b1);
        check("miss_ren", sram_ren, 1'b1);
        nxt();
        for (int g = 1; g <= gdly; g++) begin
            #1;
            st += int'(cpu_stall);
            check("req_hold", mem_req, 1'b1);
            check("req_addr", mem_addr, base);
            check("req_ren", sram_ren, 1'b0);
            mem_gnt = (g == gdly);
            nxt();
        end
        mem_gnt = sgnt;
        for (int b = 0; b < 4; b++) begin
            if (disturb && b == 1) begin
                cpu_req  = 1'b0;
                cpu_addr = 32'h1234_5670;
            end
            for (int k = 0; k < (b > 0 ? gap : 0); k++) begin
                mem_valid = 1'b0;
                #1;
                st += int'(cpu_stall);
                check("gap_blk", sram_block_addr, blk);
                nxt();
            end
            mem_valid = 1'b1;
            mem_data  = bv + 32'(b);
            #1;
            st += int'(cpu_stall);
            check("refill_req", mem_req, 1'b0);
            check("refill_blk", sram_block_addr, blk);
            nxt();
        end
        mem_valid = 1'b0;
        mem_gnt   = 1'b0;
        #1;
        st += int'(cpu_stall);
        check("wr_wen", sram_wen, 1'b1);
        check("wr_ren", sram_ren, 1'b0);
        check("wr_blk", sram_block_addr, blk);
        check("wr_line", sram_data_in, ln);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
        mem_gnt = 1'b0; mem_valid = 1'b0; mem_data = '0;
        nxt(); nxt();
        rst = 1'b0;
        #1;
        check("rst_state", 128'(dut.state_q), 128'(LOOKUP));
        check("rst_memreq", mem_req, 1'b0);
        check("rst_wen", sram_wen, 1'b0);
        check("rst_ren", sram_ren, 1'b0);
        check("rst_stall", cpu_stall, 1'b0);
        check("rst_instr", cpu_instr, 32'd0);
        check("rst_line", sram_data_in, 128'd0);
        nxt();
        // Basic miss at 0x40, 1-cycle grant, back-to-back beats
        cpu_req = 1'b1; cpu_addr = 32'h40;
        refill(32'h40, 32'hA0, 1, 0, 1'b0, 1'b0, stalls);
        check("t1_stalls", stalls, 7);
        nxt();
        #1;
        check("t1_wen_done", sram_wen, 1'b0);
        check("t1_hit_stall", cpu_stall, 1'b0);
        check("t1_hit_instr", cpu_instr, 32'hA0);
        // Same-block hit on the last word
        cpu_addr = 32'h4C;
        #1;
        check("t2_stall", cpu_stall, 1'b0);
        check("t2_instr", cpu_instr, 32'hA3);
        check("t2_memreq", mem_req, 1'b0);
        nxt();
        #1;
        check("t2_memreq_after", mem_req, 1'b0);
        check("t2_state", 128'(dut.state_q), 128'(LOOKUP));
        // Slow grant and gapped beats
        cpu_addr = 32'h100;
        refill(32'h100, 32'hB0, 3, 2, 1'b0, 1'b0, stalls);
        check("t3_stalls", stalls, 15);
        nxt();
        cpu_addr = 32'h108;
        #1;
        check("t3_hit_instr", cpu_instr, 32'hB2);
        check("t3_hit_stall", cpu_stall, 1'b0);
        nxt();
        // Fetch side walks away mid-refill
        cpu_addr = 32'h200;
        refill(32'h200, 32'hD0, 2, 1, 1'b1, 1'b0, stalls);
        check("t4_stalls", stalls, 11);
        nxt();
        #1;
        check("t4_idle_stall", cpu_stall, 1'b0);
        cpu_req = 1'b1; cpu_addr = 32'h204;
        #1;
        check("t4_hit_stall", cpu_stall, 1'b0);
        check("t4_hit_instr", cpu_instr, 32'hD1);
        nxt();
        // Reset after 2 beats discards the partial line
        cpu_addr = 32'h80;
        nxt();
        mem_gnt = 1'b1;
        nxt();
        mem_gnt = 1'b0; mem_valid = 1'b1; mem_data = 32'hC0;
        nxt();
        mem_data = 32'hC1;
        nxt();
        mem_valid = 1'b0; rst = 1'b1;
        nxt();
        rst = 1'b0; cpu_req = 1'b0;
        #1;
        check("t5_state", 128'(dut.state_q), 128'(LOOKUP));
        check("t5_memreq", mem_req, 1'b0);
        check("t5_wen", sram_wen, 1'b0);
        check("t5_line", sram_data_in, 128'd0);
        nxt();
        #1;
        check("t5_wen_later", sram_wen, 1'b0);
        cpu_req = 1'b1; cpu_addr = 32'h80;
        #1;
        check("t5_remiss", cpu_stall, 1'b1);
        nxt();
        mem_gnt = 1'b1;
        nxt();
        mem_gnt = 1'b0; mem_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            mem_data = 32'hC0 + 32'(b);
            if (b == 3) rst = 1'b1;
            nxt();
        end
        rst = 1'b0; mem_valid = 1'b0; cpu_req = 1'b0;
        #1;
        check("t5_last_rst_wen", sram_wen, 1'b0);
        check("t5_last_rst_state", 128'(dut.state_q), 128'(LOOKUP));
        nxt();
        // Spurious grant during REFILL, then spurious beat in LOOKUP
        cpu_req = 1'b1; cpu_addr = 32'h300;
        refill(32'h300, 32'hE0, 1, 1, 1'b0, 1'b1, stalls);
        check("t6_stalls", stalls, 10);
        nxt();
        cpu_req = 1'b0; mem_valid = 1'b1; mem_data = 32'hDEAD;
        #1;
        check("t6_stall", cpu_stall, 1'b0);
        nxt();
        mem_valid = 1'b0;
        #1;
        check("t6_state", 128'(dut.state_q), 128'(LOOKUP));
        check("t6_line", sram_data_in, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        check("t6_memreq", mem_req, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
